// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring divider for div/mod; signed path enabled by DIV_SIGNED_EN
module div_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivBusy,
  output logic             DivDone,
  output logic             DivByZero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;     // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;
  logic             done_q;

  // One restoring step: trial subtraction is WIDTH+1 bits wide so a borrow shows in the top bit
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             step_ok;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvs_q};
  assign step_ok  = ~diff[WIDTH];
  assign step_rem = step_ok ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign step_quo = {quo_q[WIDTH-2:0], step_ok};

`ifdef DIV_SIGNED_EN
  logic qneg_q, qneg_d;   // quotient must be negated in FIX
  logic rneg_q, rneg_d;   // remainder follows the dividend sign
  logic dvd_neg, dvs_neg;

  assign dvd_neg = Signed & Dividend[WIDTH-1];
  assign dvs_neg = Signed & Divisor[WIDTH-1];
`else
  logic unused_signed;
  assign unused_signed = Signed;
`endif

  // Stall is combinational so the issuing cycle already holds the pipeline
  assign DivBusy   = ((state_q == IDLE) && Start) || (state_q == RUN) || (state_q == FIX);
  assign DivDone   = done_q;
  assign Quotient  = quot_q;
  assign Remainder = remo_q;
  assign DivByZero = dbz_q;

  // Next-state and datapath updates for the divide sequence
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      IDLE: begin
        if (Start) begin
          if (Divisor == '0) begin
            state_d = DONE;
            quot_d  = '1;
            remo_d  = Dividend;
            dbz_d   = 1'b1;
          end else begin
`ifdef DIV_SIGNED_EN
            quo_d  = dvd_neg ? -Dividend : Dividend;
            dvs_d  = dvs_neg ? -Divisor : Divisor;
            qneg_d = dvd_neg ^ dvs_neg;
            rneg_d = dvd_neg;
`else
            quo_d  = Dividend;
            dvs_d  = Divisor;
`endif
            rem_d   = '0;
            cnt_d   = CW'(WIDTH - 1);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0) begin
`ifdef DIV_SIGNED_EN
          state_d = FIX;
`else
          state_d = DONE;
          quot_d  = step_quo;
          remo_d  = step_rem;
          dbz_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef DIV_SIGNED_EN
      FIX: begin
        quot_d  = qneg_q ? -quo_q : quo_q;
        remo_d  = rneg_q ? -rem_q : rem_q;
        dbz_d   = 1'b0;
        state_d = DONE;
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset discards any in-flight divide
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
      done_q  <= (state_d == DONE);
`ifdef DIV_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

endmodule
